// File: rtl/zircon_keypad_scan_logic.sv
// 4x4 matrix keypad scanner: row strobe, frame snapshot, single-key debounce FSM
// and a valid/ack holding register. Optional auto-repeat under `KEY_REPEAT_EN.
module zircon_keypad_scan_logic #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 20,
  parameter int REPEAT_DELAY    = 250,
  parameter int REPEAT_RATE     = 50
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  output logic [3:0] coe_key_row,
  input  logic [3:0] coe_key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_ovf,
  output logic       key_pressed,
  output logic [1:0] dbg_state
);

  // Handshake: key_valid stays high until key_ack is seen for one cycle; an
  // event arriving while key_valid is high and unacknowledged is dropped and
  // flagged on key_ovf.

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] TICK_MAX = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_MAX   = 8'(DEBOUNCE_FRAMES);

  logic [3:0]  col_meta_q, col_sync_q;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  row_cnt_q, row_cnt_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] snap_q, snap_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  cand_q, cand_d;
  logic        evt_q, evt_d, press_evt, rpt_evt;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d, ovf_q, ovf_d;

  logic        tick, frame_end, frame_onehot, cand_match;
  logic [3:0]  pressed, frame_idx;
  logic [15:0] frame;

  assign pressed      = ~col_sync_q;
  assign tick         = (tick_cnt_q == TICK_MAX);
  assign frame_end    = tick && (row_cnt_q == 2'd3);
  assign frame        = {pressed, snap_q[11:0]};
  assign frame_onehot = (frame != 16'd0) && ((frame & (frame - 16'd1)) == 16'd0);
  assign cand_match   = (frame == (16'd1 << cand_q));
  assign cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    frame_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) frame_idx = 4'(i);
    end
  end

  // Each row's columns are captured at the end of its slot, after settling.
  always_comb begin
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    row_cnt_d  = row_cnt_q;
    row_d      = row_q;
    snap_d     = snap_q;
    if (tick) begin
      row_cnt_d = row_cnt_q + 2'd1;
      row_d     = ~(4'b0001 << row_cnt_d);
      snap_d[{row_cnt_q, 2'b00} +: 4] = pressed;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    press_evt = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (frame_onehot) begin
            cand_d = frame_idx;
            if (DB_MAX <= 8'd1) begin
              state_d   = S_HELD;
              press_evt = 1'b1;
              cnt_d     = 8'd0;
            end else begin
              state_d = S_PRESS_WAIT;
              cnt_d   = 8'd1;
            end
          end
        end
        S_PRESS_WAIT: begin
          if (!cand_match) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_inc >= DB_MAX) begin
            state_d   = S_HELD;
            press_evt = 1'b1;
            cnt_d     = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_HELD: begin
          if (frame == 16'd0) begin
            if (DB_MAX <= 8'd1) begin
              state_d = S_IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = S_RELEASE_WAIT;
              cnt_d   = 8'd1;
            end
          end
        end
        default: begin
          if (frame != 16'd0) begin
            state_d = S_HELD;
            cnt_d   = 8'd0;
          end else if (cnt_inc >= DB_MAX) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] RPT_DELAY = 8'(REPEAT_DELAY);
  localparam logic [7:0] RPT_RATE  = 8'(REPEAT_RATE);

  logic [7:0] rpt_q, rpt_d, rpt_inc;
  logic       rpt_seen_q, rpt_seen_d;

  assign rpt_inc = (rpt_q == 8'hFF) ? rpt_q : rpt_q + 8'd1;

  // After the first repeat the counter restarts and targets the shorter rate.
  always_comb begin
    rpt_d      = rpt_q;
    rpt_seen_d = rpt_seen_q;
    rpt_evt    = 1'b0;
    if (frame_end) begin
      if (state_q == S_HELD && cand_match) begin
        if (rpt_inc >= (rpt_seen_q ? RPT_RATE : RPT_DELAY)) begin
          rpt_evt    = 1'b1;
          rpt_d      = 8'd0;
          rpt_seen_d = 1'b1;
        end else begin
          rpt_d = rpt_inc;
        end
      end else begin
        rpt_d      = 8'd0;
        rpt_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rpt_q      <= 8'd0;
      rpt_seen_q <= 1'b0;
    end else begin
      rpt_q      <= rpt_d;
      rpt_seen_q <= rpt_seen_d;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign rpt_evt = 1'b0;
`endif

  assign evt_d = press_evt | rpt_evt;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (evt_q) begin
      if (!valid_q || key_ack) begin
        code_d  = cand_q;
        valid_d = 1'b1;
        if (key_ack) ovf_d = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (key_ack) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
      tick_cnt_q <= 16'd0;
      row_cnt_q  <= 2'd0;
      row_q      <= 4'b1110;
      snap_q     <= 16'd0;
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      cand_q     <= 4'd0;
      evt_q      <= 1'b0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      col_meta_q <= coe_key_col;
      col_sync_q <= col_meta_q;
      tick_cnt_q <= tick_cnt_d;
      row_cnt_q  <= row_cnt_d;
      row_q      <= row_d;
      snap_q     <= snap_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      evt_q      <= evt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign coe_key_row = row_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_ovf     = ovf_q;
  assign key_pressed = (state_q == S_HELD) || (state_q == S_RELEASE_WAIT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_zircon_keypad_scan_logic.sv
// Directed bench for zircon_keypad_scan_logic: a behavioural keypad matrix,
// frame-aligned stimulus and hand-computed expectations (SCAN_DIV=4, 3 frames).
module tb_zircon_keypad_scan_logic;

  localparam int FRAME = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic        ack;
  logic        ovf;
  logic        pressed;
  logic [1:0]  dbg_state;
  logic [15:0] keys;

  int n_tests;
  int n_fail;
  int cyc;

  zircon_keypad_scan_logic #(
    .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .CLK_50M(clk), .RST_N(rst_n), .coe_key_row(row), .coe_key_col(col),
    .key_code(code), .key_valid(valid), .key_ack(ack), .key_ovf(ovf),
    .key_pressed(pressed), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4 + c]) col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  task automatic align();
    while (cyc % FRAME != 0) tick();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic release_all();
    align();
    keys = 16'd0;
    frames(3);
    check("released", {15'd0, pressed}, 16'd0);
  endtask

  logic any_flag;
  logic [15:0] exp_q[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    keys    = 16'd0;
    ack     = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row",     {12'd0, row},  16'b1110);
    check("rst_code",    {12'd0, code}, 16'd0);
    check("rst_valid",   {15'd0, valid}, 16'd0);
    check("rst_ovf",     {15'd0, ovf}, 16'd0);
    check("rst_pressed", {15'd0, pressed}, 16'd0);
    check("rst_state",   {14'd0, dbg_state}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Row strobe sequence, one change every 4 clocks
    exp_q = '{16'b1101, 16'b1011, 16'b0111, 16'b1110};
    while (exp_q.size() > 0) begin
      repeat (4) tick();
      check("row_seq", {12'd0, row}, exp_q.pop_front());
    end
    any_flag = 1'b0;
    repeat (192) begin
      tick();
      any_flag = any_flag | valid | ovf | pressed;
    end
    check("idle_flags", {15'd0, any_flag}, 16'd0);

    // Stable press of key 6
    align();
    keys = 16'd1 << 6;
    frames(1);
    check("k6_press_wait", {14'd0, dbg_state}, 16'd1);
    frames(2);
    check("k6_pressed", {15'd0, pressed}, 16'd1);
    check("k6_latency", {15'd0, valid}, 16'd0);
    tick();
    check("k6_valid", {15'd0, valid}, 16'd1);
    check("k6_code", {12'd0, code}, 16'd6);
    ack_pulse();
    check("k6_ack", {15'd0, valid}, 16'd0);
    align();
    frames(1);
    check("k6_single_evt", {15'd0, valid}, 16'd0);
    keys = 16'd0;
    frames(2);
    check("k6_rel_wait", {15'd0, pressed}, 16'd1);
    frames(1);
    check("k6_released", {15'd0, pressed}, 16'd0);

    // Bounce: two frames, a gap, then stable
    keys = 16'd1 << 6;
    frames(2);
    keys = 16'd0;
    frames(1);
    keys = 16'd1 << 6;
    frames(2);
    check("bnc_no_press", {15'd0, pressed}, 16'd0);
    check("bnc_no_valid", {15'd0, valid}, 16'd0);
    frames(1);
    tick();
    check("bnc_valid", {15'd0, valid}, 16'd1);
    check("bnc_code", {12'd0, code}, 16'd6);
    ack_pulse();
    release_all();

    // Two keys held: ignored until one is released
    keys = (16'd1 << 0) | (16'd1 << 5);
    frames(4);
    check("two_no_press", {15'd0, pressed}, 16'd0);
    check("two_no_valid", {15'd0, valid}, 16'd0);
    keys = 16'd1 << 0;
    frames(3);
    tick();
    check("two_valid", {15'd0, valid}, 16'd1);
    check("two_code", {12'd0, code}, 16'd0);
    ack_pulse();
    release_all();

    // Overflow: key 3 unconsumed, then key 12
    keys = 16'd1 << 3;
    frames(3);
    tick();
    check("ovf_k3_code", {12'd0, code}, 16'd3);
    release_all();
    keys = 16'd1 << 12;
    frames(3);
    tick();
    check("ovf_code_kept", {12'd0, code}, 16'd3);
    check("ovf_valid", {15'd0, valid}, 16'd1);
    check("ovf_flag", {15'd0, ovf}, 16'd1);
    ack_pulse();
    check("ovf_ack_valid", {15'd0, valid}, 16'd0);
    check("ovf_ack_flag", {15'd0, ovf}, 16'd0);
    release_all();

    // Ack on the exact event cycle replaces the code without overflow
    keys = 16'd1 << 3;
    frames(3);
    tick();
    check("ackevt_k3", {15'd0, valid}, 16'd1);
    release_all();
    keys = 16'd1 << 12;
    frames(3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ackevt_code", {12'd0, code}, 16'd12);
    check("ackevt_valid", {15'd0, valid}, 16'd1);
    check("ackevt_ovf", {15'd0, ovf}, 16'd0);
    ack_pulse();
    release_all();

`ifdef KEY_REPEAT_EN
    // Auto-repeat for key 9 with ack held high: events after frames 3, 7, 9, 11
    exp_q = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
    keys = 16'd1 << 9;
    ack  = 1'b1;
    frames(1);
    for (int f = 1; f <= 12; f++) begin
      logic [15:0] e;
      tick();
      e = exp_q.pop_front();
      check("rpt_valid", {15'd0, valid}, e);
      if (e != 16'd0) check("rpt_code", {12'd0, code}, 16'd9);
      if (f < 12) repeat (FRAME - 1) tick();
    end
    ack = 1'b0;
    release_all();
`endif

    // Reset mid-frame discards the pending event and restarts the scan
    keys = 16'd1 << 6;
    frames(3);
    repeat (6) tick();
    check("mid_valid_pre", {15'd0, valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", {12'd0, row}, 16'b1110);
    check("mid_rst_valid", {15'd0, valid}, 16'd0);
    check("mid_rst_pressed", {15'd0, pressed}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zircon_keypad_scan_logic.md
Name: zircon_keypad_scan_logic

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart to the multiplexed segment display driver. It drives one keypad row low at a time and reads the four column pins.
- Builds a 16-key snapshot per frame, debounces single-key presses over whole frames, and presents a key code to user logic through a valid/ack holding register.
- Sits between the keypad pins and the Avalon slave register logic.

Parameters:
- SCAN_DIV, 50000: clocks per row slot (1 ms at 50 MHz); legal range 4..65535.
- DEBOUNCE_FRAMES, 20: consecutive matching frames required to accept a press or a release; legal range 1..255.
- REPEAT_DELAY, 250: frames held before the first auto-repeat; used only with KEY_REPEAT_EN.
- REPEAT_RATE, 50: frames between later repeats; used only with KEY_REPEAT_EN.

Ports:
- CLK_50M  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- coe_key_row  output  4  row drive, active-low, exactly one bit low
- coe_key_col  input  4  column sense; pulled up, low means pressed
- key_code  output  4  accepted key index, row*4+col
- key_valid  output  1  key_code holds an unconsumed event
- key_ack  input  1  one-cycle consume strobe from user logic
- key_ovf  output  1  sticky flag: an event was lost
- key_pressed  output  1  high while the debounced state is HELD or RELEASE_WAIT

Behaviour:
- Reset: the clock is CLK_50M and reset is RST_N, asynchronous and active-low. Reset values:
  - coe_key_row=4'b1110, row_cnt=0, tick_cnt=0.
  - column synchroniser=4'b1111, snapshot=0.
  - state=IDLE, debounce counter=0.
  - key_code=0, key_valid=0, key_ovf=0, key_pressed=0.
- Columns: pass through a 2-FF synchroniser; pressed bits = ~col_sync.
- Scan timing:
  - tick_cnt counts 0..SCAN_DIV-1 and wraps; tick = (tick_cnt==SCAN_DIV-1).
  - On tick: snapshot[row_cnt*4 +: 4] <= ~col_sync; row_cnt increments mod 4; coe_key_row <= ~(1<<next row).
  - Sampling happens at the end of the slot, so the row drive plus synchroniser have settled.
- Frame end: the tick with row_cnt==3. frame = {~col_sync, snapshot[11:0]} is evaluated combinationally. One frame = 4*SCAN_DIV clocks.
- FSM, evaluated only at frame end:
  - IDLE: if frame is one-hot, go to PRESS_WAIT with cand=index and cnt=1; otherwise stay. Multi-key frames are ignored (ghosting).
  - PRESS_WAIT: if frame==one-hot(cand), cnt++; when cnt reaches DEBOUNCE_FRAMES, go to HELD and emit an event with code cand. Any other frame returns to IDLE with cnt=0.
  - HELD: if frame==0, go to RELEASE_WAIT with cnt=1; any nonzero frame stays in HELD, including a change of key.
  - RELEASE_WAIT: if frame==0, cnt++; when cnt reaches DEBOUNCE_FRAMES, go to IDLE. A nonzero frame returns to HELD.
  - DEBOUNCE_FRAMES=1 makes the transition immediate on the first qualifying frame.
- Event to holding register, registered with 1 clock latency after the frame-end edge:
  - key_valid=0: key_code<=cand, key_valid<=1.
  - key_valid=1 and no key_ack in the same cycle: key_code is unchanged, key_ovf<=1.
  - key_valid=1 and key_ack in the same cycle: key_code<=cand, key_valid stays 1, no overflow.
  - key_ack with no event: key_valid<=0 and key_ovf<=0. An ack while key_valid=0 has no effect except clearing key_ovf.
- Arithmetic: tick_cnt is 16 bits; the debounce and repeat counters are 8 bits and saturate, never wrapping.
- Reset mid-frame aborts the scan and restarts at row 0; pending events are discarded.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts frames in which frame==one-hot(cand).
  - The first repeat event is emitted at REPEAT_DELAY, then one every REPEAT_RATE frames.
  - Repeat events use the same holding/overflow rules as a press.
  - The counter clears on leaving HELD, or on a frame that is not exactly one-hot(cand).
- Undefined: no repeat logic is built; REPEAT_DELAY and REPEAT_RATE are unused; exactly one event per press.

Test Plan (all scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 clocks):
- Reset, no key:
  - coe_key_row cycles 1110, 1101, 1011, 0111, changing every 4 clocks.
  - key_valid, key_ovf and key_pressed stay 0 for 200 clocks.
- Stable press of key 6:
  - Stimulus: col[2] low whenever row 1 is driven, held for 5 frames.
  - Response: key_valid rises 1 clock after the end of the 3rd matching frame with key_code=6, and key_pressed=1.
  - Pulse key_ack: key_valid=0.
- Bounce:
  - Stimulus: key 6 for 2 frames, one frame open, then stable.
  - Response: no event until 3 consecutive matching frames after the gap.
- Two keys held (0 and 5):
  - Response: no event while both are held.
  - Release key 5: event with code 0 after 3 frames.
- Overflow:
  - Stimulus: press key 3 (no ack), release it fully, press key 12.
  - Response: key_code stays 3 and key_ovf=1. key_ack clears both flags.
  - Repeat with key_ack on the exact event cycle: key_code=12, key_valid=1, key_ovf=0.
- With KEY_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, key 9 held for 12 frames:
  - Events with code 9 occur at press, then at the 4th HELD frame, then every 2nd frame after that.
  - key_ack is applied every cycle.
